// File: rtl/mdu_pkg.sv
// Shared encodings and op-class helpers for the multiply/divide sequencer.
// Build option: define MDU_DIV_EN to implement DIV/DIVU (otherwise they decode as NONE).
package mdu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [OP_W-1:0] op);
`ifdef MDU_DIV_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

    function automatic logic is_move_op(input logic [OP_W-1:0] op);
        return (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the pending HI/LO pair.
// Build option: MDU_DIV_EN includes the divider; without it only MULT/MULTU compute.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [31:0]     cur_hi,
    input  logic [31:0]     cur_lo,
    output logic [31:0]     res_hi,
    output logic [31:0]     res_lo
);

    // One 33x33 signed multiplier serves both MULT and MULTU via the extension bit.
    logic               mul_signed;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic [63:0]        prod;

    assign mul_signed = (op == MD_MULT);
    assign mul_a      = $signed({mul_signed & a[31], a});
    assign mul_b      = $signed({mul_signed & b[31], b});
    assign prod       = 64'(mul_a) * 64'(mul_b);

`ifdef MDU_DIV_EN
    // Signed divide runs on magnitudes, so INT_MIN / -1 wraps to INT_MIN with zero remainder.
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign div_signed = (op == MD_DIV);
    assign a_mag      = (div_signed && a[31]) ? (32'd0 - a) : a;
    assign b_mag      = (div_signed && b[31]) ? (32'd0 - b) : b;
    assign q_mag      = a_mag / b_mag;
    assign r_mag      = a_mag % b_mag;
    assign quot       = (div_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    assign rem        = (div_signed && a[31]) ? (32'd0 - r_mag) : r_mag;
`endif

    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
`ifdef MDU_DIV_EN
            MD_DIV, MD_DIVU: begin
                if (b != 32'd0) begin
                    res_hi = rem;
                    res_lo = quot;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer holding architectural HI/LO and the D-stage stall request.
// Build option: MDU_DIV_EN enables DIV/DIVU; otherwise they act as NONE.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] E_mdOp,
    input  logic            E_start,
    input  logic [31:0]     E_rs,
    input  logic [31:0]     E_rt,
    input  logic            D_mdInstr,
    output logic            busy,
    output logic            D_mdStall,
    output logic [31:0]     hi,
    output logic [31:0]     lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        arith_hi;
    logic [31:0]        arith_lo;
    logic               is_mul;

    mdu_arith u_arith (
        .op     (E_mdOp),
        .a      (E_rs),
        .b      (E_rt),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    assign is_mul = (E_mdOp == MD_MULT) || (E_mdOp == MD_MULTU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Starts are only honoured in IDLE; the pending result commits on the last busy edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (E_start) begin
                    if (is_long_op(E_mdOp)) begin
                        res_hi_d = arith_hi;
                        res_lo_d = arith_lo;
                        cnt_d    = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d  = S_RUN;
                    end else if (is_move_op(E_mdOp)) begin
                        if (E_mdOp == MD_MTHI) begin
                            hi_d = E_rs;
                        end else begin
                            lo_d = E_rs;
                        end
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_RUN);
    assign D_mdStall = D_mdInstr & (busy | (E_start & is_long_op(E_mdOp)));
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer against an arithmetic reference model.
// Expectations follow the MDU_DIV_EN build option when it is defined.
module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MDU_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_mdOp;
    logic        E_start;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_mdInstr;
    logic        busy;
    logic        D_mdStall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_sequencer #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .E_mdOp    (E_mdOp),
        .E_start   (E_start),
        .E_rs      (E_rs),
        .E_rt      (E_rt),
        .D_mdInstr (D_mdInstr),
        .busy      (busy),
        .D_mdStall (D_mdStall),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(busy && E_start)) else $error("start issued while busy");
        end
    end

    // Architectural effect of one issued op on m_hi/m_lo, plus its busy length.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        logic [63:0]        p;
        logic signed [63:0] sa, sb, q, r;
        n = 0;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                m_hi = p[63:32];
                m_lo = p[31:0];
                n = MULT_N;
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                n = MULT_N;
            end
            OP_DIV: begin
                if (DIV_EN) begin
                    n = DIV_N;
                    if (b != 32'd0) begin
                        sa = $signed(a);
                        sb = $signed(b);
                        q = sa / sb;
                        r = sa % sb;
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                    end
                end
            end
            OP_DIVU: begin
                if (DIV_EN) begin
                    n = DIV_N;
                    if (b != 32'd0) begin
                        m_lo = a / b;
                        m_hi = a % b;
                    end
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issues one op in the current cycle and follows it until the unit is idle again.
    task automatic test_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic start, input logic instr, input string tag);
        logic [31:0] old_hi, old_lo;
        int n, k;
        old_hi = m_hi;
        old_lo = m_lo;
        n = 0;
        if (start) model(op, a, b, n);
        E_mdOp = op; E_rs = a; E_rt = b; E_start = start; D_mdInstr = instr;
        #1;
        checks++;
        if (D_mdStall !== (instr && (n > 0))) begin
            errors++;
            $display("FAIL %s start_stall: got %b want %b", tag, D_mdStall, (instr && (n > 0)));
        end
        @(posedge clk); #1;
        E_start = 1'b0;
        E_mdOp = 3'($urandom_range(0, 7));
        E_rs = $urandom;
        E_rt = $urandom;
        k = 0;
        while (busy === 1'b1 && k < 100) begin
            checks++;
            if (hi !== old_hi || lo !== old_lo) begin
                errors++;
                $display("FAIL %s hold cyc%0d: got %h_%h want %h_%h", tag, k, hi, lo, old_hi, old_lo);
            end
            checks++;
            if (D_mdStall !== instr) begin
                errors++;
                $display("FAIL %s busy_stall cyc%0d: got %b want %b", tag, k, D_mdStall, instr);
            end
            k++;
            @(posedge clk); #1;
        end
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL %s busy_len: got %0d want %0d", tag, k, n);
        end
        checks++;
        if (busy !== 1'b0 || D_mdStall !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: got busy=%b stall=%b want 0 0", tag, busy, D_mdStall);
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL %s result: got %h_%h want %h_%h", tag, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; E_start = 1'b0; E_mdOp = OP_NONE; E_rs = '0; E_rt = '0; D_mdInstr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
        D_mdInstr = 1'b1;
        #1;
        checks++;
        if (D_mdStall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_idle: got %b want 0", D_mdStall);
        end
        E_start = 1'b1; E_mdOp = OP_MULT;
        #1;
        checks++;
        if (D_mdStall !== 1'b1) begin
            errors++;
            $display("FAIL stall_mult_start: got %b want 1", D_mdStall);
        end
        E_mdOp = OP_DIV;
        #1;
        checks++;
        if (D_mdStall !== DIV_EN) begin
            errors++;
            $display("FAIL stall_div_start: got %b want %b", D_mdStall, DIV_EN);
        end
        E_start = 1'b0; E_mdOp = OP_NONE; D_mdInstr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_plan_vectors();
        test_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, "mult_neg2x3");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa", hi, lo);
        end
        test_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, "multu_max");
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_const: got %h_%h want fffffffe_00000001", hi, lo);
        end
        test_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, "div_neg7by2");
        test_op(OP_MTHI, 32'h0000_1234, 32'd0, 1'b1, 1'b0, "mthi");
        test_op(OP_MTLO, 32'h0000_5678, 32'd0, 1'b1, 1'b0, "mtlo");
        test_op(OP_DIVU, 32'h0000_0099, 32'd0, 1'b1, 1'b1, "divu_by0");
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
            errors++;
            $display("FAIL divu_by0_const: got %h_%h want 00001234_00005678", hi, lo);
        end
        test_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_ovf");
        test_op(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, "mtlo_deadbeef");
        checks++;
        if (lo !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mtlo_const: got %h want deadbeef", lo);
        end
        test_op(OP_MULT, 32'd7, 32'd9, 1'b0, 1'b1, "mult_nostart");
    endtask

    task automatic test_reset_in_run();
        test_op(OP_MTHI, 32'hA5A5_0001, 32'd0, 1'b1, 1'b0, "pre_mthi");
        E_start = 1'b1; E_mdOp = OP_MULT; E_rs = 32'd1000; E_rt = 32'd1000; D_mdInstr = 1'b0;
        @(posedge clk); #1;
        E_start = 1'b0; E_mdOp = OP_NONE;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_run_busy3: got %b want 1", busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_abandon: got hi=%h lo=%h busy=%b want 0 0 0", hi, lo, busy);
        end
        m_hi = '0;
        m_lo = '0;
        test_op(OP_MULT, 32'h0001_0000, 32'h0003_0000, 1'b1, 1'b1, "mult_after_rst");
    endtask

    task automatic test_back_to_back();
        test_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, "b2b_a");
        test_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, "b2b_b");
        test_op(OP_DIVU,  32'hFFFF_FFFF, 32'd16, 1'b1, 1'b0, "b2b_c");
        test_op(OP_MTHI,  32'h0BAD_F00D, 32'd0, 1'b1, 1'b0, "b2b_d");
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        st, ins;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            st  = ($urandom_range(0, 9) != 0);
            ins = 1'($urandom_range(0, 1));
            test_op(op, a, b, st, ins, $sformatf("rnd%0d_op%0d", i, op));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m_hi = '0;
        m_lo = '0;
        test_reset();
        test_plan_vectors();
        test_reset_in_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
